control_unit: RTL and testbench

//   Multicycle RV32I main controller: Moore FSM plus ALU decoder.

---
 rtl/control_unit.sv | 158 +++++++++++++++
 tb/tb_control_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Multicycle RV32I main controller: Moore FSM sequencing fetch/decode/execute/writeback,
// plus the ALU decoder for R-type and I-type ALU instructions.
module control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic       mem_write,
    output logic       reg_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       instruction_or_data,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [3:0] current_state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        ALUWB    = 4'd7,
        EXECUTEI = 4'd8,
        JAL      = 4'd9
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_t     state;
    logic [2:0] funct_op;

    // Only funct7[5] distinguishes sub from add; the other bits are don't-care here.
    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    assign current_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:  state <= DECODE;
                DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: state <= MEMADR;
                        OP_R:         state <= EXECUTER;
                        OP_IALU:      state <= EXECUTEI;
                        OP_JAL:       state <= JAL;
                        default:      state <= FETCH;
                    endcase
                end
                MEMADR:   state <= (opcode == OP_LW) ? MEMREAD : MEMWRITE;
                MEMREAD:  state <= MEMWB;
                MEMWB:    state <= FETCH;
                MEMWRITE: state <= FETCH;
                EXECUTER: state <= ALUWB;
                ALUWB:    state <= FETCH;
                EXECUTEI: state <= ALUWB;
                JAL:      state <= ALUWB;
                default:  state <= FETCH;
            endcase
        end
    end

    always_comb begin
        funct_op = ALU_ADD;
        case (funct3)
            3'b000:  funct_op = (opcode[5] && funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b010:  funct_op = ALU_SLT;
            3'b110:  funct_op = ALU_OR;
            3'b111:  funct_op = ALU_AND;
            default: funct_op = ALU_ADD;
        endcase
    end

    always_comb begin
        mem_write           = 1'b0;
        reg_write           = 1'b0;
        ir_write            = 1'b0;
        pc_write            = 1'b0;
        instruction_or_data = 1'b0;
        result_src          = 2'b00;
        alu_src_a           = 2'b00;
        alu_src_b           = 2'b00;
        alu_control         = ALU_ADD;
        case (state)
            FETCH: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            MEMREAD: begin
                instruction_or_data = 1'b1;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            MEMWRITE: begin
                instruction_or_data = 1'b1;
                mem_write           = 1'b1;
            end
            EXECUTER: begin
                alu_src_a   = 2'b10;
                alu_control = funct_op;
            end
            ALUWB: begin
                reg_write = 1'b1;
            end
            EXECUTEI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = funct_op;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
        // Write enables must never pulse while reset is held, even mid-instruction.
        if (reset) begin
            mem_write = 1'b0;
            reg_write = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit: per-instruction state sequences and
// the full output vector in every state, ALU decode variants and reset behaviour.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       mem_write, reg_write, ir_write, pc_write, instruction_or_data;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] alu_control;
    logic [3:0] current_state;

    int errors = 0;
    int checks = 0;

    control_unit dut (
        .clk                 (clk),
        .reset               (reset),
        .opcode              (opcode),
        .funct3              (funct3),
        .funct7              (funct7),
        .mem_write           (mem_write),
        .reg_write           (reg_write),
        .ir_write            (ir_write),
        .pc_write            (pc_write),
        .instruction_or_data (instruction_or_data),
        .result_src          (result_src),
        .alu_src_a           (alu_src_a),
        .alu_src_b           (alu_src_b),
        .alu_control         (alu_control),
        .current_state       (current_state)
    );

    always #5 clk = ~clk;

    // Observed outputs packed as {mw,rw,irw,pcw,iod,rs,a,b,alu,state}.
    logic [17:0] obs;
    assign obs = {mem_write, reg_write, ir_write, pc_write, instruction_or_data,
                  result_src, alu_src_a, alu_src_b, alu_control, current_state};

    function automatic logic [17:0] ev(input logic mw, input logic rw, input logic irw,
                                       input logic pcw, input logic iod, input logic [1:0] rs,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [2:0] alu, input logic [3:0] st);
        return {mw, rw, irw, pcw, iod, rs, a, b, alu, st};
    endfunction

    // Hand-written expected vectors for each state.
    logic [17:0] E_FETCH, E_DECODE, E_MEMADR, E_MEMREAD, E_MEMWB, E_MEMWRITE;
    logic [17:0] E_EXER_SUB, E_ALUWB, E_EXEI_ADD, E_JAL;
    initial begin
        E_FETCH    = ev(0, 0, 1, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 4'd0);
        E_DECODE   = ev(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 4'd1);
        E_MEMADR   = ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 4'd2);
        E_MEMREAD  = ev(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 4'd3);
        E_MEMWB    = ev(0, 1, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 4'd4);
        E_MEMWRITE = ev(1, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 4'd5);
        E_EXER_SUB = ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 4'd6);
        E_ALUWB    = ev(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'd7);
        E_EXEI_ADD = ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 4'd8);
        E_JAL      = ev(0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, 3'b000, 4'd9);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_instr(input logic [31:0] instr);
        opcode = instr[6:0];
        funct3 = instr[14:12];
        funct7 = instr[31:25];
    endtask

    task automatic test_reset();
        reset = 1'b1;
        load_instr(32'h0000_0013);
        step();
        checks++;
        if (current_state !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d want 0", current_state);
        end
        checks++;
        if ({mem_write, reg_write, ir_write, pc_write} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_enables: got %b want 0000",
                     {mem_write, reg_write, ir_write, pc_write});
        end
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== E_FETCH) begin
            errors++;
            $display("FAIL first_fetch: got %h want %h", obs, E_FETCH);
        end
    endtask

    // Runs one instruction from FETCH, checking every cycle, and ends back in FETCH.
    task automatic run_instr(input string name, input logic [31:0] instr,
                             input int n, input logic [17:0] seq [6]);
        load_instr(instr);
        for (int i = 0; i < n; i++) begin
            checks++;
            if (obs !== seq[i]) begin
                errors++;
                $display("FAIL %s cycle%0d: got %h want %h", name, i, obs, seq[i]);
            end
            step();
        end
        checks++;
        if (current_state !== 4'd0) begin
            errors++;
            $display("FAIL %s return: state got %0d want 0", name, current_state);
        end
    endtask

    task automatic test_sw();
        logic [17:0] s [6];
        s = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMWRITE, '0, '0};
        run_instr("sw", 32'h0011_2023, 4, s);
    endtask

    task automatic test_lw();
        logic [17:0] s [6];
        s = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMREAD, E_MEMWB, '0};
        run_instr("lw", 32'h0001_2083, 5, s);
    endtask

    task automatic test_r_sub();
        logic [17:0] s [6];
        s = '{E_FETCH, E_DECODE, E_EXER_SUB, E_ALUWB, '0, '0};
        run_instr("sub", 32'h4020_81B3, 4, s);
    endtask

    task automatic test_addi();
        logic [17:0] s [6];
        s = '{E_FETCH, E_DECODE, E_EXEI_ADD, E_ALUWB, '0, '0};
        run_instr("addi", 32'hFFF0_8193, 4, s);
    endtask

    task automatic test_jal();
        logic [17:0] s [6];
        s = '{E_FETCH, E_DECODE, E_JAL, E_ALUWB, '0, '0};
        run_instr("jal", 32'h0080_00EF, 4, s);
    endtask

    task automatic test_unsupported();
        logic [17:0] s [6];
        s = '{E_FETCH, E_DECODE, '0, '0, '0, '0};
        run_instr("op7f", 32'h0000_007F, 2, s);
        run_instr("beq", 32'h0020_8463, 2, s);
    endtask

    // Execute-state ALU op for several funct combinations.
    task automatic test_alu_decode();
        logic [31:0] instrs [7];
        logic [3:0]  st_want [7];
        logic [2:0]  alu_want [7];
        instrs   = '{32'h0020_81B3, 32'h0020_E1B3, 32'h0020_F1B3, 32'h0020_A1B3,
                     32'h0020_91B3, 32'h0010_E193, 32'h4010_8193};
        st_want  = '{4'd6, 4'd6, 4'd6, 4'd6, 4'd6, 4'd8, 4'd8};
        alu_want = '{3'b000, 3'b011, 3'b010, 3'b101, 3'b000, 3'b011, 3'b000};
        for (int i = 0; i < 7; i++) begin
            load_instr(instrs[i]);
            step();
            step();
            checks++;
            if (current_state !== st_want[i] || alu_control !== alu_want[i]) begin
                errors++;
                $display("FAIL alu_decode%0d: state %0d alu %b want state %0d alu %b",
                         i, current_state, alu_control, st_want[i], alu_want[i]);
            end
            step();
            step();
        end
    endtask

    task automatic test_reset_midinstr();
        load_instr(32'h0001_2083);
        step();
        step();
        step();
        checks++;
        if (current_state !== 4'd3) begin
            errors++;
            $display("FAIL mid_reach: state got %0d want 3", current_state);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({mem_write, reg_write, ir_write, pc_write} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset_enables: got %b want 0000",
                     {mem_write, reg_write, ir_write, pc_write});
        end
        step();
        checks++;
        if (current_state !== 4'd0 || {mem_write, reg_write, ir_write, pc_write} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset_state: state %0d en %b want 0 0000", current_state,
                     {mem_write, reg_write, ir_write, pc_write});
        end
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== E_FETCH) begin
            errors++;
            $display("FAIL mid_reset_fetch: got %h want %h", obs, E_FETCH);
        end
    endtask

    initial begin
        reset  = 1'b1;
        opcode = '0;
        funct3 = '0;
        funct7 = '0;
        #2;
        test_reset();
        test_sw();
        test_lw();
        test_r_sub();
        test_addi();
        test_jal();
        test_unsupported();
        test_alu_decode();
        test_reset_midinstr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
